// File: rtl/mmio_uart_pkg.sv
// Shared types and register map for the memory-mapped UART transmitter.
// The PARITY state exists only when UART_PARITY_EN is defined.
package mmio_uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } uart_state_t;

    localparam logic [1:0] TXDATA_OFF  = 2'd0;
    localparam logic [1:0] STATUS_OFF  = 2'd1;
    localparam logic [1:0] BAUDDIV_OFF = 2'd2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted only when a pop
// happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push)
                wptr <= wptr + 1'b1;
            if (do_pop)
                rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS/BAUDDIV registers, TX FIFO
// and frame FSM. Define UART_PARITY_EN to add an even-parity bit.
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0400,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] RESET_DIV  = 16'd434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        tx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          sel;
    logic [1:0]    off;
    logic          wr_tx;
    logic          wr_stat;
    logic          wr_div;
    logic          is_stat;
    logic          is_div;
    logic [15:0]   bauddiv;
    logic          ovf;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic [3:0]    cnt4;
    logic [7:0]    fdout;
    logic          pop;
    logic          busy;
    logic          unused;

    uart_state_t   state, state_n;
    logic [7:0]    sh, sh_n;
    logic [15:0]   per, per_n;
    logic [15:0]   bcnt, bcnt_n;
    logic [2:0]    nbit, nbit_n;
    logic          tx_n;
    logic          bit_end;
`ifdef UART_PARITY_EN
    logic          par, par_n;
`endif

    assign sel     = (a[31:4] == BASE_ADDR[31:4]);
    assign off     = a[3:2];
    assign wr_tx   = we && sel && (off == TXDATA_OFF);
    assign wr_stat = we && sel && (off == STATUS_OFF);
    assign wr_div  = we && sel && (off == BAUDDIV_OFF);
    assign is_stat = sel && (off == STATUS_OFF);
    assign is_div  = sel && (off == BAUDDIV_OFF);
    assign busy    = (state != IDLE);
    assign cnt4    = 4'(count);
    assign bit_end = (bcnt == per - 16'd1);
    assign unused  = &{1'b0, a[1:0], wd[31:16]};

    always_comb begin
        rd = '0;
        unique case (1'b1)
            is_stat: rd = {24'b0, cnt4, ovf, empty, full, busy};
            is_div:  rd = {16'b0, bauddiv};
            default: rd = '0;
        endcase
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_tx),
        .pop   (pop),
        .din   (wd[7:0]),
        .dout  (fdout),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            bauddiv <= RESET_DIV;
            ovf     <= 1'b0;
        end else begin
            if (wr_div)
                bauddiv <= (wd[15:0] == 16'd0) ? 16'd1 : wd[15:0];
            if (wr_tx && full && !pop)
                ovf <= 1'b1;
            else if (wr_stat && wd[3])
                ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            tx    <= 1'b1;
            sh    <= '0;
            per   <= RESET_DIV;
            bcnt  <= '0;
            nbit  <= '0;
`ifdef UART_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_n;
            tx    <= tx_n;
            sh    <= sh_n;
            per   <= per_n;
            bcnt  <= bcnt_n;
            nbit  <= nbit_n;
`ifdef UART_PARITY_EN
            par   <= par_n;
`endif
        end
    end

    // A frame starts by popping the FIFO head and latching the divider,
    // from IDLE or straight out of STOP.
    always_comb begin
        state_n = state;
        sh_n    = sh;
        per_n   = per;
        bcnt_n  = bcnt + 16'd1;
        nbit_n  = nbit;
        tx_n    = tx;
        pop     = 1'b0;
`ifdef UART_PARITY_EN
        par_n   = par;
`endif
        unique case (state)
            IDLE: begin
                bcnt_n = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = START;
                    tx_n    = 1'b0;
                    sh_n    = fdout;
                    per_n   = bauddiv;
                    nbit_n  = '0;
`ifdef UART_PARITY_EN
                    par_n   = ^fdout;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    bcnt_n  = '0;
                    nbit_n  = '0;
                    state_n = DATA;
                    tx_n    = sh[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    bcnt_n = '0;
                    if (nbit == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_n = PARITY;
                        tx_n    = par;
`else
                        state_n = STOP;
                        tx_n    = 1'b1;
`endif
                        nbit_n  = '0;
                    end else begin
                        nbit_n = nbit + 3'd1;
                        sh_n   = {1'b0, sh[7:1]};
                        tx_n   = sh[1];
                    end
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    bcnt_n  = '0;
                    state_n = STOP;
                    tx_n    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    bcnt_n = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        state_n = START;
                        tx_n    = 1'b0;
                        sh_n    = fdout;
                        per_n   = bauddiv;
                        nbit_n  = '0;
`ifdef UART_PARITY_EN
                        par_n   = ^fdout;
`endif
                    end else begin
                        state_n = IDLE;
                        tx_n    = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
                bcnt_n  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register access, frame waveforms,
// FIFO overflow, back-to-back frames and mid-frame reset.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'h0000_0400;
`ifdef UART_PARITY_EN
    localparam int FLEN = 11;
`else
    localparam int FLEN = 10;
`endif
    localparam int HSZ = 4096;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        tx;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic txhist [HSZ];
    logic [7:0] expq [$];

    mmio_uart_tx #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (4),
        .RESET_DIV  (16'd434)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .a     (a),
        .wd    (wd),
        .rd    (rd),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (cyc < HSZ)
            txhist[cyc] = tx;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, required finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        we = 1'b1;
        a  = addr;
        wd = data;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic load(input logic [31:0] addr, output logic [31:0] data);
        @(negedge clk);
        we = 1'b0;
        a  = addr;
        #1;
        data = rd;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic check_frame(input int t0, input int p, input string tag);
        logic [7:0]  b;
        logic [7:0]  obs;
        logic [10:0] fb;
        int bad;
        chk({tag, "_queued"}, 32'(expq.size() != 0), 32'd1);
        if (expq.size() == 0)
            return;
        b = expq.pop_front();
        fb = '1;
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++)
            fb[i+1] = b[i];
`ifdef UART_PARITY_EN
        fb[9] = ^b;
`endif
        wait_cyc(t0 + FLEN * p + 1);
        bad = 0;
        for (int i = 0; i < FLEN; i++)
            for (int k = 0; k < p; k++)
                if (txhist[t0 + i * p + k] !== fb[i])
                    bad++;
        for (int i = 0; i < 8; i++)
            obs[i] = txhist[t0 + (i + 1) * p + p / 2];
        chk({tag, "_byte"}, {24'b0, obs}, {24'b0, b});
        chk({tag, "_wave_errs"}, bad, 0);
    endtask

    initial begin
        logic [31:0] r;
        int e;
        int t;
        int ones;
        reset = 1'b1;
        we    = 1'b0;
        a     = '0;
        wd    = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", {31'b0, tx}, 32'd1);
        load(BASE + 32'h4, r);
        chk("rst_status", r, 32'h4);
        load(BASE + 32'h8, r);
        chk("rst_baud", r, 32'd434);
        reset = 1'b0;
        @(posedge clk);
        #1;

        load(BASE + 32'h0, r);
        chk("txdata_read", r, 32'h0);
        store(BASE + 32'h8, 32'h0);
        load(BASE + 32'h8, r);
        chk("baud_zero", r, 32'd1);
        store(BASE + 32'hC, 32'h1234);
        load(BASE + 32'h8, r);
        chk("off_c_store", r, 32'd1);
        load(BASE + 32'hC, r);
        chk("off_c_read", r, 32'h0);
        load(BASE + 32'h10, r);
        chk("unsel_read", r, 32'h0);

        store(BASE + 32'h8, 32'hFFFF_0004);
        load(BASE + 32'h8, r);
        chk("baud_4", r, 32'd4);
        @(posedge clk);
        #1;
        store(BASE + 32'h0, 32'h55);
        e = cyc;
        expq.push_back(8'h55);
        load(BASE + 32'h4, r);
        chk("status_queued", r, 32'h10);
        check_frame(e + 1, 4, "f55");
        chk("f55_idle_before", {31'b0, txhist[e]}, 32'd1);
        load(BASE + 32'h4, r);
        chk("status_after_55", r, 32'h4);

        @(posedge clk);
        #1;
        store(BASE + 32'h0, 32'hA1);
        e = cyc;
        store(BASE + 32'h0, 32'h3C);
        store(BASE + 32'h0, 32'hF0);
        store(BASE + 32'h0, 32'h0F);
        store(BASE + 32'h0, 32'h96);
        store(BASE + 32'h0, 32'h77);
        expq.push_back(8'hA1);
        expq.push_back(8'h3C);
        expq.push_back(8'hF0);
        expq.push_back(8'h0F);
        expq.push_back(8'h96);
        load(BASE + 32'h4, r);
        chk("status_ovf", r, 32'h4B);
        @(posedge clk);
        #1;
        store(BASE + 32'h4, 32'h8);
        load(BASE + 32'h4, r);
        chk("status_clr", r, 32'h43);
        @(posedge clk);
        #1;
        store(BASE + 32'h8, 32'h2);
        t = e + 1;
        check_frame(t, 4, "burst0");
        t += FLEN * 4;
        for (int i = 1; i < 5; i++) begin
            check_frame(t, 2, $sformatf("burst%0d", i));
            t += FLEN * 2;
        end
        wait_cyc(t + 12);
        ones = 0;
        for (int i = 0; i < 10; i++)
            if (txhist[t + i] === 1'b1)
                ones++;
        chk("burst_idle_after", ones, 10);
        chk("burst_queue_left", expq.size(), 0);
        load(BASE + 32'h4, r);
        chk("status_burst_end", r, 32'h4);

        store(BASE + 32'h8, 32'h4);
        @(posedge clk);
        #1;
        store(BASE + 32'h0, 32'hC3);
        e = cyc;
        store(BASE + 32'h0, 32'h81);
        t = e + 1;
        wait_cyc(t + 14);
        reset = 1'b1;
        we    = 1'b1;
        a     = BASE + 32'h8;
        wd    = 32'h7;
        @(posedge clk);
        #1;
        reset = 1'b0;
        we    = 1'b0;
        chk("midrst_tx", {31'b0, tx}, 32'd1);
        load(BASE + 32'h4, r);
        chk("midrst_status", r, 32'h4);
        load(BASE + 32'h8, r);
        chk("midrst_baud", r, 32'd434);
        wait_cyc(t + 80);
        chk("midrst_inframe", {31'b0, txhist[t + 14]}, 32'd0);
        ones = 0;
        for (int i = 15; i < 75; i++)
            if (txhist[t + i] === 1'b1)
                ones++;
        chk("midrst_discard", ones, 60);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 Parameter BASE_ADDR, 32'h0000_0400, byte address of the register window; bits [3:0] are zero.
REQ-002 Parameter FIFO_DEPTH, 4, number of TX FIFO entries; a power of two, at least 2.
REQ-003 Parameter RESET_DIV, 16'd434, reset value of BAUDDIV.
REQ-004 clk  in  1  the single clock; every register updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 we  in  1  store strobe from the core's memory stage (MemWriteM).
REQ-007 a  in  32  data address from the core's memory stage (ALUResultM).
REQ-008 wd  in  32  store data (WriteDataM).
REQ-009 rd  out  32  load data, muxed onto ReadDataM by the top level.
REQ-010 tx  out  1  serial output, registered; high when idle.

Function
REQ-011 The block is selected when a[31:4] == BASE_ADDR[31:4]; offsets are taken from a[3:2].
REQ-012 Offset 0x0, TXDATA: a selected store pushes wd[7:0] into the FIFO; a load returns 0.
REQ-013 Offset 0x4, STATUS (read): bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), bits[7:4] FIFO count; all other bits are 0.
REQ-014 A store to STATUS with wd[3]=1 clears overflow; all other STATUS bits are read-only.
REQ-015 Offset 0x8, BAUDDIV: read/write, bits [15:0]; a written value of 0 is stored as 1.
REQ-016 Offset 0xC reads 0 and ignores stores; an unselected address drives rd = 0.
REQ-017 rd is combinational from a, with zero-cycle latency, matching the dmem read timing.
REQ-018 A push when full and no pop in the same cycle is dropped and sets overflow; a push and pop in the same cycle are both accepted, including when the FIFO is full.
REQ-019 The FSM has states IDLE, START, DATA, PARITY, STOP.
REQ-020 In IDLE with the FIFO non-empty, the FSM pops on that edge, loads the shift register, latches BAUDDIV into the bit-period register, and enters START.
REQ-021 A byte pushed at edge E into an empty FIFO with the FSM in IDLE makes tx go low at edge E+1.
REQ-022 Each bit lasts exactly the latched BAUDDIV cycles; a BAUDDIV write mid-frame applies from the next frame.
REQ-023 The frame is START (0), then DATA (8 bits, LSB first), then PARITY (only when enabled), then STOP (1).
REQ-024 From STOP: with the FIFO non-empty the FSM pops and goes directly to START, with no idle gap; otherwise it goes to IDLE.
REQ-025 The bit counter and baud counter wrap to 0 at each bit and frame boundary; they never overflow.

Reset
REQ-026 While reset is high: tx=1, FSM=IDLE, FIFO pointers and count=0, overflow=0, BAUDDIV=RESET_DIV, and counters=0.
REQ-027 Reset asserted mid-frame aborts the frame; tx is high from the next edge and queued bytes are discarded.
REQ-028 Reset overrides a simultaneous store.

Configuration
REQ-029 When UART_PARITY_EN is defined, the PARITY state exists and sends even parity (XOR of the 8 data bits), so a frame is 11 bits.
REQ-030 When UART_PARITY_EN is undefined, the PARITY state and its logic are omitted and DATA goes directly to STOP, so a frame is 10 bits.

Structure
REQ-031 Package mmio_uart_pkg holds the FSM state enum and the register offset constants (TXDATA_OFF, STATUS_OFF, BAUDDIV_OFF).
REQ-032 The FIFO is a separate sub-module, sync_fifo, parameterised by width and depth, with push, pop, full, empty and count ports.

Verification
REQ-033 Store BAUDDIV=4, then store TXDATA=0x55: tx is low for 4 cycles starting at the edge after the store, then shows 1,0,1,0,1,0,1,0 at 4 cycles per bit, then stop high; the frame is 40 cycles, or 44 with UART_PARITY_EN and parity bit 0.
REQ-034 Store six bytes to TXDATA on consecutive cycles with FIFO_DEPTH=4: the first is popped, the next four are queued, the sixth is dropped, and STATUS reads 0x4B (count 4, overflow, full, busy).
REQ-035 After REQ-034, store STATUS=0x8: overflow clears, and the five accepted bytes go out back-to-back with no idle gaps between frames.
REQ-036 Assert reset for one cycle at cycle 15 of a frame: tx=1 from the next edge, STATUS reads 0x4, and BAUDDIV reads 434.
REQ-037 Store BAUDDIV=0 and read it back: the read returns 1; a load from BASE_ADDR+0xC and a load from BASE_ADDR+0x10 both return 0.
